axi2apb_apb_master: RTL and testbench

- Consumer side of the AXI-to-APB bridge command queue: takes one queued 32-bit single-beat AXI command at a time and runs one APB3 transfer for it.
- For writes it collects the W beat; it returns the B or R response and pulses finish_wr/finish_rd to pop the queue.
- It sits between the command queue outputs and up to 16 APB slaves (PSEL one-hot), behind an external PRDATA/PREADY/PSLVERR mux.

---
 rtl/axi2apb_apb_master.sv | 123 ++++++++++++
 tb/tb_axi2apb_apb_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi2apb_apb_master.sv
// axi2apb_apb_master: runs one APB3 transfer per queued single-beat AXI command and returns its B/R response
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cmd_*             head of the command queue (held stable until finish_wr/finish_rd pops it)
//   finish_wr/rd      one-cycle pop pulses, asserted in the B/R handshake cycle
//   W*/B*/R*          AXI write data, write response and read data channels
//   P*                APB3 master interface, PSEL one-hot over 16 slaves
module axi2apb_apb_master #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_empty,
    input  logic                        cmd_read,
    input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
    input  logic [APB_ADDR_WIDTH+3:0]   cmd_addr,
    input  logic                        cmd_err,
    output logic                        finish_wr,
    output logic                        finish_rd,
    input  logic [31:0]                 WDATA,
    input  logic [3:0]                  WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [AXI_ID_WIDTH-1:0]     RID,
    output logic [31:0]                 RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [15:0]                 PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic [31:0]                 PWDATA,
    input  logic [31:0]                 PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);
    typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_RESP} state_t;
    localparam int CW = APB_TIMEOUT > 1 ? $clog2(APB_TIMEOUT + 1) : 1;
    localparam logic [CW:0] TMO = APB_TIMEOUT[CW:0];

    state_t          state, state_n;
    logic            wready_q;
    logic [31:0]     pwdata_q, rdata_q;
    logic [1:0]      resp_q;
    logic [CW-1:0]   cnt;
    logic            w_hs, w_err, tmo, done, resp_hs, active;
    logic            unused_wlast;

    assign unused_wlast = WLAST;
    assign w_hs    = state == ST_WDATA && WVALID && wready_q;
    assign w_err   = cmd_err || WSTRB != 4'hF;
    // The cycle that would bring the wait count to APB_TIMEOUT ends the transfer, unless PREADY arrives in it.
    assign tmo     = APB_TIMEOUT != 0 && !PREADY && ({1'b0, cnt} + 1'b1) == TMO;
    assign done    = state == ST_ACCESS && (PREADY || tmo);
    assign resp_hs = state == ST_RESP && (cmd_read ? RREADY : BREADY);
    assign active  = state == ST_SETUP || state == ST_ACCESS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (!cmd_empty) state_n = cmd_read ? (cmd_err ? ST_RESP : ST_SETUP) : ST_WDATA;
            ST_WDATA:  if (w_hs) state_n = w_err ? ST_RESP : ST_SETUP;
            ST_SETUP:  state_n = ST_ACCESS;
            ST_ACCESS: if (done) state_n = ST_RESP;
            ST_RESP:   if (resp_hs) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wready_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            resp_q   <= '0;
            cnt      <= '0;
        end else begin
            wready_q <= state == ST_WDATA && !w_hs;
            cnt      <= (state == ST_ACCESS && !done && APB_TIMEOUT != 0) ? cnt + 1'b1 : '0;
            if (w_hs) pwdata_q <= WDATA;
            if (state == ST_IDLE && !cmd_empty && cmd_read && cmd_err) begin
                resp_q  <= 2'b10;
                rdata_q <= '0;
            end
            if (w_hs && w_err) resp_q <= 2'b10;
            if (done) begin
                resp_q  <= (tmo || PSLVERR) ? 2'b10 : 2'b00;
                rdata_q <= (cmd_read && PREADY && !PSLVERR) ? PRDATA : '0;
            end
        end
    end

    assign WREADY    = wready_q;
    assign PSEL      = active ? 16'd1 << cmd_addr[APB_ADDR_WIDTH +: 4] : '0;
    assign PENABLE   = state == ST_ACCESS;
    assign PWRITE    = active && !cmd_read;
    assign PADDR     = active ? cmd_addr[APB_ADDR_WIDTH-1:0] : '0;
    assign PWDATA    = pwdata_q;
    assign BVALID    = state == ST_RESP && !cmd_read;
    assign RVALID    = state == ST_RESP && cmd_read;
    assign BID       = BVALID ? cmd_id : '0;
    assign BRESP     = BVALID ? resp_q : '0;
    assign RID       = RVALID ? cmd_id : '0;
    assign RRESP     = RVALID ? resp_q : '0;
    assign RDATA     = RVALID ? rdata_q : '0;
    assign RLAST     = RVALID;
    assign finish_wr = BVALID && BREADY;
    assign finish_rd = RVALID && RREADY;
endmodule

// File: tb/tb_axi2apb_apb_master.sv
// tb_axi2apb_apb_master: table-driven and randomized transaction checks of axi2apb_apb_master
module tb_axi2apb_apb_master;
    localparam int TMO_P = 8;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_empty = 1'b1, cmd_read = 1'b0, cmd_err = 1'b0;
    logic [5:0]  cmd_id = '0;
    logic [15:0] cmd_addr = '0;
    logic        finish_wr, finish_rd;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b1, WVALID = 1'b0, WREADY;
    logic [5:0]  BID, RID;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY = 1'b0;
    logic [31:0] RDATA;
    logic        RLAST, RVALID, RREADY = 1'b0;
    logic [15:0] PSEL;
    logic        PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    int tests = 0, fails = 0;

    axi2apb_apb_master #(.AXI_ID_WIDTH(6), .APB_ADDR_WIDTH(12), .APB_TIMEOUT(TMO_P)) dut (
        .clk(clk), .reset(reset), .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_err(cmd_err), .finish_wr(finish_wr), .finish_rd(finish_rd),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit [5:0]  id;
        bit [15:0] addr;
        bit        err;
        bit [31:0] wdata;
        bit [3:0]  wstrb;
        int        wdly;
        int        waits;
        bit        slverr;
        bit [31:0] prdata;
        int        bp;
        bit [15:0] e_psel;
        bit [1:0]  e_resp;
        bit [31:0] e_rdata;
        int        e_pen;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        bit apb = v.rd ? !v.err : (!v.err && v.wstrb == 4'hF);
        bit to = v.waits >= TMO_P;
        m.e_psel  = apb ? 16'd1 << v.addr[15:12] : 16'h0;
        m.e_pen   = !apb ? 0 : to ? TMO_P : v.waits + 1;
        m.e_resp  = (!apb || to || v.slverr) ? 2'b10 : 2'b00;
        m.e_rdata = (v.rd && m.e_resp == 2'b00) ? v.prdata : 32'h0;
        return m;
    endfunction

    task automatic run(input vec_t v);
        logic [15:0] c_psel = '0;
        logic [11:0] c_paddr = '0;
        logic        c_pwrite = 1'b0;
        logic [31:0] c_pwdata = '0;
        logic [82:0] rec = '0;
        logic [5:0]  r_id = '0;
        logic [1:0]  r_resp = '0;
        logic [31:0] r_data = '0;
        logic        r_last = 1'b0;
        int pen = 0, acc = 0, bp = 0, lat = 0, cyc = 0;
        bit seen = 0, done = 0, w_done = 0, hs = 0, early = 0, unstable = 0, bp_bad = 0, multi = 0;
        bit apb = v.e_psel != 0;
        @(negedge clk);
        cmd_read = v.rd; cmd_id = v.id; cmd_addr = v.addr; cmd_err = v.err;
        WDATA = v.wdata; WSTRB = v.wstrb; WVALID = 1'b0; cmd_empty = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (hs) begin
                hs = 0; w_done = 1; WVALID = 1'b0;
            end
            if (!v.rd && !w_done && cyc > v.wdly) WVALID = 1'b1;
            if (WVALID && WREADY) hs = 1;
            if (PSEL != 0) begin
                if (!seen) begin
                    seen = 1; c_psel = PSEL; c_paddr = PADDR; c_pwrite = PWRITE; c_pwdata = PWDATA;
                end else if ({c_psel, c_paddr, c_pwrite, c_pwdata} !== {PSEL, PADDR, PWRITE, PWDATA}) unstable = 1;
                if (!v.rd && !w_done) early = 1;
            end
            if (!$onehot0(PSEL) || (BVALID && RVALID) || (finish_wr && finish_rd)) multi = 1;
            if (PENABLE) begin
                pen++;
                PREADY  = acc == v.waits;
                PSLVERR = PREADY ? v.slverr : 1'($urandom_range(0, 1));
                PRDATA  = PREADY ? v.prdata : $urandom;
                acc++;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b0;
            end
            if (BVALID || RVALID) begin
                if (lat == 0) begin
                    lat = cyc;
                    rec = {BVALID, RVALID, BID, BRESP, RID, RRESP, RDATA, RLAST};
                    r_id = BVALID ? BID : RID; r_resp = BVALID ? BRESP : RRESP; r_data = RDATA; r_last = RLAST;
                end else if (rec !== {BVALID, RVALID, BID, BRESP, RID, RRESP, RDATA, RLAST}) bp_bad = 1;
                if (finish_wr || finish_rd) bp_bad = 1;
                if (bp < v.bp) bp++;
                else begin
                    BREADY = !v.rd; RREADY = v.rd;
                    #1;
                    check("finish_pulse", {finish_wr, finish_rd}, v.rd ? 2'b01 : 2'b10);
                    @(negedge clk);
                    check("post_handshake_idle", {BVALID, RVALID, finish_wr, finish_rd, PSEL}, 0);
                    BREADY = 1'b0; RREADY = 1'b0; cmd_empty = 1'b1;
                    done = 1;
                end
            end
        end
        PREADY = 1'b0;
        check("txn_done", done, 1);
        check("psel", c_psel, v.e_psel);
        check("paddr", c_paddr, apb ? v.addr[11:0] : 12'h0);
        check("pwrite", c_pwrite, apb && !v.rd);
        if (!v.rd && apb) check("pwdata", c_pwdata, v.wdata);
        check("penable_cycles", pen, v.e_pen);
        check("resp", r_resp, v.e_resp);
        check("id", r_id, v.id);
        if (v.rd) begin
            check("rdata", r_data, v.e_rdata);
            check("rlast", r_last, 1);
            check("read_latency", lat, apb ? 2 + v.e_pen : 1);
        end else begin
            check("w_consumed", w_done, 1);
            check("psel_before_w", early, 0);
        end
        check("resp_hold", bp_bad, 0);
        check("exclusive", multi, 0);
        check("apb_stable", unstable, 0);
    endtask

    vec_t tv[11];

    initial begin
        // rd, id, addr, err, wdata, wstrb, wdly, waits, slverr, prdata, bp, e_psel, e_resp, e_rdata, e_pen
        tv[0]  = '{1'b1, 6'd5,  16'h20AC, 1'b0, 32'h0,        4'hF, 0, 2,  1'b0, 32'hDEADBEEF, 1,  16'h0004, 2'b00, 32'hDEADBEEF, 3};
        tv[1]  = '{1'b0, 6'd3,  16'hF010, 1'b0, 32'h12345678, 4'hF, 4, 0,  1'b0, 32'h0,        10, 16'h8000, 2'b00, 32'h0,        1};
        tv[2]  = '{1'b1, 6'd7,  16'h1004, 1'b1, 32'h0,        4'hF, 0, 0,  1'b0, 32'h55555555, 0,  16'h0000, 2'b10, 32'h0,        0};
        tv[3]  = '{1'b0, 6'd9,  16'h3000, 1'b0, 32'hAAAA5555, 4'h3, 1, 0,  1'b0, 32'h0,        2,  16'h0000, 2'b10, 32'h0,        0};
        tv[4]  = '{1'b1, 6'd11, 16'h5FFC, 1'b0, 32'h0,        4'hF, 0, 1,  1'b1, 32'hCAFE0000, 0,  16'h0020, 2'b10, 32'h0,        2};
        tv[5]  = '{1'b1, 6'd12, 16'h7123, 1'b0, 32'h0,        4'hF, 0, 30, 1'b0, 32'h01020304, 0,  16'h0080, 2'b10, 32'h0,        8};
        tv[6]  = '{1'b1, 6'h3F, 16'h0000, 1'b0, 32'h0,        4'hF, 0, 0,  1'b0, 32'hA5A5A5A5, 0,  16'h0001, 2'b00, 32'hA5A5A5A5, 1};
        tv[7]  = '{1'b0, 6'd1,  16'h1111, 1'b1, 32'h0BADF00D, 4'hF, 0, 0,  1'b0, 32'h0,        0,  16'h0000, 2'b10, 32'h0,        0};
        tv[8]  = '{1'b0, 6'd2,  16'hA004, 1'b0, 32'h87654321, 4'hF, 2, 3,  1'b1, 32'h0,        1,  16'h0400, 2'b10, 32'h0,        4};
        tv[9]  = '{1'b1, 6'd4,  16'h6008, 1'b0, 32'h0,        4'hF, 0, 7,  1'b0, 32'h11223344, 0,  16'h0040, 2'b00, 32'h11223344, 8};
        tv[10] = '{1'b0, 6'd6,  16'h9ABC, 1'b0, 32'hFEEDFACE, 4'hF, 0, 8,  1'b0, 32'h0,        0,  16'h0200, 2'b10, 32'h0,        8};
        repeat (3) @(negedge clk);
        check("reset_outputs", |{finish_wr, finish_rd, WREADY, BID, BRESP, BVALID, RID, RDATA, RRESP, RLAST,
                                 RVALID, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) run(tv[i]);
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.rd = 1'($urandom_range(0, 1)); v.id = 6'($urandom); v.addr = 16'($urandom);
            v.err = $urandom_range(0, 7) == 0; v.wdata = $urandom;
            v.wstrb = $urandom_range(0, 3) != 0 ? 4'hF : 4'($urandom);
            v.wdly = $urandom_range(0, 5); v.waits = $urandom_range(0, 10);
            v.slverr = $urandom_range(0, 3) == 0; v.prdata = $urandom; v.bp = $urandom_range(0, 3);
            run(model(v));
        end
        begin
            int n = 0;
            @(negedge clk);
            cmd_read = 1'b1; cmd_id = 6'd8; cmd_addr = 16'h4100; cmd_err = 1'b0; cmd_empty = 1'b0; PREADY = 1'b0;
            while (!PENABLE && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reach_access", PENABLE, 1);
            #2 reset = 1'b1;
            #1;
            check("async_reset_outputs", |{finish_wr, finish_rd, WREADY, BID, BRESP, BVALID, RID, RDATA, RRESP,
                                           RLAST, RVALID, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
            cmd_empty = 1'b1;
            repeat (2) @(negedge clk);
            check("no_resp_after_reset", {BVALID, RVALID, PSEL}, 0);
            reset = 1'b0;
            run(tv[0]);
            run(tv[1]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
